// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the MULT/DIV sequencing controller.
//   state_e            - controller state encoding
//   op_e               - latched operation (MULT=0, DIV=1)
//   TIMEOUT_CYCLES_DEF - default WAIT-state cycle budget before a hang abort
//   cnt_width()        - wait-counter width needed for a given budget
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_EXC   = 3'd5
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/muldiv_wait_counter.sv
// wait_counter: cycle counter for the controller's WAIT state.
//   clk     - system clock, rising edge
//   reset   - asynchronous active-low reset
//   clear   - synchronous clear (held while not waiting)
//   enable  - count one per cycle
//   limit   - terminal count
//   expired - count has reached limit (holds there)
module wait_counter #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == limit);

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one MULT or DIV through an external unit and
// loads HI/LO with its result.
//   clk, reset            - clock (rising edge), async active-low reset
//   req_mult, req_div     - operation requests (MULT wins if both)
//   abort                 - flush; returns to IDLE, suppresses any write
//   divisor               - DIV operand B, checked for zero at accept
//   mult_ready, div_ready - result-valid from the external units
//   mult_start, div_start - one-cycle unit start pulses
//   hi_wr, lo_wr, hilo_sel- HI/LO load strobes and source select (1 = divider)
//   busy                  - operation in flight (START/WAIT/WRITE)
//   done, div_zero, timeout - one-cycle completion / exception pulses
// All outputs are flops; nothing combinational reaches a port.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_mult,
    input  logic        req_div,
    input  logic        abort,
    input  logic [31:0] divisor,
    input  logic        mult_ready,
    input  logic        div_ready,
    output logic        mult_start,
    output logic        div_start,
    output logic        hi_wr,
    output logic        lo_wr,
    output logic        hilo_sel,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        timeout
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

    state_e           r_state;
    op_e              r_op;
    logic             r_mult_start;
    logic             r_div_start;
    logic             r_hi_wr;
    logic             r_lo_wr;
    logic             r_hilo_sel;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;
    logic             r_timeout;

    logic             w_cnt_clear;
    logic             w_cnt_en;
    logic             w_expired;
    logic             w_sel_ready;
    logic [CNT_W-1:0] w_limit;

    assign w_limit     = CNT_W'(TIMEOUT_CYCLES - 1);
    // Counter is held at zero outside WAIT, so it reads 0 on the first WAIT cycle.
    assign w_cnt_clear = (r_state != ST_WAIT);
    assign w_cnt_en    = (r_state == ST_WAIT);
    assign w_sel_ready = (r_op == OP_DIV) ? div_ready : mult_ready;

    wait_counter #(
        .WIDTH(CNT_W)
    ) u_wait_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_cnt_clear),
        .enable (w_cnt_en),
        .limit  (w_limit),
        .expired(w_expired)
    );

    // Outputs are registered alongside the transition into the state that
    // owns them, so each pulse is visible exactly while that state is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_MULT;
            r_mult_start <= 1'b0;
            r_div_start  <= 1'b0;
            r_hi_wr      <= 1'b0;
            r_lo_wr      <= 1'b0;
            r_hilo_sel   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_div_zero   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_mult_start <= 1'b0;
            r_div_start  <= 1'b0;
            r_hi_wr      <= 1'b0;
            r_lo_wr      <= 1'b0;
            r_done       <= 1'b0;
            r_div_zero   <= 1'b0;
            r_timeout    <= 1'b0;

            if (abort) begin
                r_state    <= ST_IDLE;
                r_busy     <= 1'b0;
                r_hilo_sel <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (req_mult) begin
                            r_op         <= OP_MULT;
                            r_state      <= ST_START;
                            r_mult_start <= 1'b1;
                            r_busy       <= 1'b1;
                            r_hilo_sel   <= 1'b0;
                        end else if (req_div) begin
                            if (divisor == '0) begin
                                r_state    <= ST_EXC;
                                r_div_zero <= 1'b1;
                            end else begin
                                r_op        <= OP_DIV;
                                r_state     <= ST_START;
                                r_div_start <= 1'b1;
                                r_busy      <= 1'b1;
                                r_hilo_sel  <= 1'b1;
                            end
                        end
                    end
                    ST_START: begin
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        // Ready on the limit cycle still wins over the timeout.
                        if (w_sel_ready) begin
                            r_state <= ST_WRITE;
                            r_hi_wr <= 1'b1;
                            r_lo_wr <= 1'b1;
                        end else if (w_expired) begin
                            r_state    <= ST_IDLE;
                            r_timeout  <= 1'b1;
                            r_busy     <= 1'b0;
                            r_hilo_sel <= 1'b0;
                        end
                    end
                    ST_WRITE: begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                    ST_DONE: begin
                        r_state    <= ST_IDLE;
                        r_hilo_sel <= 1'b0;
                    end
                    ST_EXC: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_hilo_sel <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mult_start = r_mult_start;
    assign div_start  = r_div_start;
    assign hi_wr      = r_hi_wr;
    assign lo_wr      = r_lo_wr;
    assign hilo_sel   = r_hilo_sel;
    assign busy       = r_busy;
    assign done       = r_done;
    assign div_zero   = r_div_zero;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: the stimulus side predicts the pulse
// events and busy cycles of each transaction from the sequencing rules;
// a monitor on the falling edge compares what the DUT presents.
module tb_muldiv_ctrl;

    localparam int unsigned TO = 8;

    localparam int K_MULT  = 0;
    localparam int K_DIV   = 1;
    localparam int K_BOTH  = 2;
    localparam int K_ZERO  = 3;
    localparam int K_ABORT = 4;
    localparam int K_TOUT  = 5;
    localparam int K_REQAB = 6;

    // Pulse vector order: {mult_start, div_start, hi_wr, lo_wr, done, div_zero, timeout}
    localparam logic [6:0] V_MS = 7'b1000000;
    localparam logic [6:0] V_DS = 7'b0100000;
    localparam logic [6:0] V_WR = 7'b0011000;
    localparam logic [6:0] V_DN = 7'b0000100;
    localparam logic [6:0] V_DZ = 7'b0000010;
    localparam logic [6:0] V_TO = 7'b0000001;

    typedef struct {
        int         cyc;
        logic [6:0] v;
        logic       sel;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_mult = 1'b0;
    logic        req_div = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] divisor = '0;
    logic        mult_ready = 1'b0;
    logic        div_ready = 1'b0;
    logic        mult_start, div_start, hi_wr, lo_wr, hilo_sel;
    logic        busy, done, div_zero, timeout;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    ev_t         ev_q[$];
    bit          busy_exp[int];

    muldiv_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_mult  (req_mult),
        .req_div   (req_div),
        .abort     (abort),
        .divisor   (divisor),
        .mult_ready(mult_ready),
        .div_ready (div_ready),
        .mult_start(mult_start),
        .div_start (div_start),
        .hi_wr     (hi_wr),
        .lo_wr     (lo_wr),
        .hilo_sel  (hilo_sel),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_ev(input int c, input logic [6:0] v, input logic sel);
        ev_t e;
        e.cyc = c;
        e.v   = v;
        e.sel = sel;
        ev_q.push_back(e);
    endfunction

    // Monitor: busy every cycle, pulse events whenever any pulse is visible.
    initial begin
        logic [6:0] v;
        logic       bexp;
        ev_t        e;
        forever begin
            @(negedge clk);
            while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                e = ev_q.pop_front();
                n_cmp++;
                n_fail++;
                $display("FAIL missed_event: nothing seen, expected outs=%b at cycle %0d", e.v, e.cyc);
            end
            bexp = busy_exp.exists(cyc);
            n_cmp++;
            if (busy !== bexp) begin
                n_fail++;
                $display("FAIL busy@%0d: got %b, expected %b", cyc, busy, bexp);
            end
            v = {mult_start, div_start, hi_wr, lo_wr, done, div_zero, timeout};
            if (v !== 7'b0) begin
                n_cmp++;
                if (ev_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event@%0d: got outs=%b, expected none", cyc, v);
                end else begin
                    e = ev_q.pop_front();
                    if (e.cyc != cyc || e.v !== v || (e.v[4] && hilo_sel !== e.sel)) begin
                        n_fail++;
                        $display("FAIL event@%0d: got outs=%b sel=%b, expected outs=%b sel=%b at cycle %0d",
                                 cyc, v, hilo_sel, e.v, e.sel, e.cyc);
                    end
                end
            end
        end
    end

    // One transaction starting at the current falling edge (DUT idle).
    // dforce: ready delay after the start pulse (-1 random); for K_ABORT a
    // forced delay puts the abort in the same cycle as ready.
    task automatic run_txn(input int kind, input int dforce, input int divforce);
        logic        rm[16], rd[16], ab[16], mr[16], dr[16];
        logic [31:0] dv;
        int          c, s, d, a, len, last_busy, nb;
        bit          is_div;
        for (int i = 0; i < 16; i++) begin
            rm[i] = 1'b0; rd[i] = 1'b0; ab[i] = 1'b0; mr[i] = 1'b0; dr[i] = 1'b0;
        end
        c = cyc;
        s = c + 1;
        dv = $urandom;
        if (dv == 32'd0) dv = 32'd1;
        nb = -1;
        is_div = 1'b0;
        case (kind)
            K_ZERO: begin
                rd[0] = 1'b1;
                if ($urandom_range(0, 1) == 1) rm[0] = 1'b0;
                dv = '0;
                push_ev(s, V_DZ, 1'b0);
                len = 2;
                last_busy = 1;
            end
            K_REQAB: begin
                rm[0] = ($urandom_range(0, 1) == 1);
                rd[0] = 1'b1;
                ab[0] = 1'b1;
                len = 1;
                last_busy = 0;
            end
            default: begin
                if (divforce >= 0) is_div = (divforce == 1);
                else if (kind == K_DIV) is_div = 1'b1;
                else if (kind == K_MULT || kind == K_BOTH) is_div = 1'b0;
                else is_div = ($urandom_range(0, 1) == 1);
                if (is_div) rd[0] = 1'b1;
                else begin
                    rm[0] = 1'b1;
                    if (kind == K_BOTH) rd[0] = 1'b1;
                end
                push_ev(s, is_div ? V_DS : V_MS, 1'b0);
                d = (dforce >= 0) ? dforce : $urandom_range(1, TO);
                if (kind == K_TOUT) begin
                    nb = TO;
                    push_ev(s + TO + 1, V_TO, 1'b0);
                    last_busy = TO + 1;
                    len = TO + 3;
                end else if (kind == K_ABORT) begin
                    a = (dforce >= 0) ? d : $urandom_range(0, d);
                    ab[a + 1] = 1'b1;
                    if (a == d) begin
                        if (is_div) dr[d + 1] = 1'b1; else mr[d + 1] = 1'b1;
                    end
                    nb = a;
                    last_busy = a + 1;
                    len = a + 2;
                end else begin
                    if (is_div) dr[d + 1] = 1'b1; else mr[d + 1] = 1'b1;
                    nb = d + 1;
                    push_ev(s + d + 1, V_WR, is_div);
                    push_ev(s + d + 2, V_DN, 1'b0);
                    last_busy = d + 3;
                    len = d + 4;
                end
            end
        endcase
        for (int k = 0; k <= nb; k++) busy_exp[s + k] = 1'b1;
        // Ignored traffic: requests outside IDLE, and the other unit's ready.
        for (int i = 1; i <= last_busy; i++) begin
            if ($urandom_range(0, 3) == 0) rm[i] = 1'b1;
            if ($urandom_range(0, 3) == 0) rd[i] = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                if (is_div) mr[i] = 1'b1; else dr[i] = 1'b1;
            end
        end
        for (int i = 0; i < len; i++) begin
            req_mult   = rm[i];
            req_div    = rd[i];
            abort      = ab[i];
            mult_ready = mr[i];
            div_ready  = dr[i];
            divisor    = (i == 0) ? dv : $urandom;
            @(negedge clk);
        end
        req_mult = 1'b0; req_div = 1'b0; abort = 1'b0;
        mult_ready = 1'b0; div_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        logic [8:0] o;
        o = {mult_start, div_start, hi_wr, lo_wr, hilo_sel, busy, done, div_zero, timeout};
        n_cmp++;
        if (o !== 9'b0) begin
            n_fail++;
            $display("FAIL %s: got outputs=%b, expected %b", name, o, 9'b0);
        end
    endtask

    initial begin
        int gap;
        int c;
        #1;
        check_all_zero("reset_outputs");
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);

        run_txn(K_MULT, 3, 0);
        run_txn(K_ZERO, -1, -1);
        run_txn(K_TOUT, -1, 1);
        run_txn(K_BOTH, 2, 0);
        run_txn(K_ABORT, 4, 0);
        run_txn(K_MULT, TO, 0);
        run_txn(K_DIV, 1, 1);
        run_txn(K_REQAB, -1, -1);

        for (int n = 0; n < 150; n++) begin
            run_txn(int'($urandom_range(0, 6)), -1, -1);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                mult_ready = ($urandom_range(0, 1) == 1);
                div_ready  = ($urandom_range(0, 1) == 1);
                @(negedge clk);
            end
            mult_ready = 1'b0;
            div_ready  = 1'b0;
        end

        // Asynchronous reset in the middle of a WAIT cycle.
        c = cyc;
        req_div = 1'b1;
        divisor = 32'd13;
        push_ev(c + 1, V_DS, 1'b0);
        busy_exp[c + 1] = 1'b1;
        busy_exp[c + 2] = 1'b1;
        @(negedge clk);
        req_div = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset_mid_wait");
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        run_txn(K_DIV, 2, 1);

        repeat (3) @(negedge clk);
        while (ev_q.size() > 0) begin
            ev_t e;
            e = ev_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL leftover_event: nothing seen, expected outs=%b at cycle %0d", e.v, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
